// File: rtl/seq_mul_pkg.sv
// Shared constants and helpers for the shift-and-add multiplier.
// Imported by the interface, the adder and the top level.
package seq_mul_pkg;

   localparam int DEFAULT_OPERAND_SIZE = 4;

   // The down-counter must hold the value N itself, hence N+1 states.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sequential_multiplier_if.sv
// Operand/start/result bundle for sequential_multiplier.
// The master drives the start pulse and operands; the slave returns the product.
interface sequential_multiplier_if
   import seq_mul_pkg::*;
#(
   parameter int N = DEFAULT_OPERAND_SIZE
);

   // Start protocol: sreset high at a rising edge latches A/B and restarts the
   // run. No ready/ack exists. The result is valid N edges after the last edge
   // with sreset high, and it is held until the next start.
   logic           sreset;
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic [2*N:0]   Product;

   modport master (
      output sreset,
      output A,
      output B,
      input  Product
   );

   modport slave (
      input  sreset,
      input  A,
      input  B,
      output Product
   );

endinterface

// File: rtl/seq_mul_adder.sv
// N-bit unsigned adder with carry-out.
// Provides the ACC + M step of each multiplier iteration.
module seq_mul_adder
   import seq_mul_pkg::*;
#(
   parameter int N = DEFAULT_OPERAND_SIZE
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         carry
);

   assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier, one multiplier bit per clock.
// A start latches A/B; the product is ready N edges later and then held.
module sequential_multiplier
   import seq_mul_pkg::*;
#(
   parameter int OPERAND_SIZE = DEFAULT_OPERAND_SIZE
) (
   input  logic                  clk,
   input  logic                  areset,
   sequential_multiplier_if.slave bus
);

   localparam int N  = OPERAND_SIZE;
   localparam int CW = cnt_width(N);

   logic [N-1:0]  m;
   logic [N-1:0]  acc;
   logic [N-1:0]  q;
   logic          c;
   logic [CW-1:0] cnt;

   logic [N-1:0]  sum;
   logic          carry;
   logic [N-1:0]  acc_add;
   logic          c_add;

   seq_mul_adder #(
      .N (N)
   ) u_adder (
      .a     (acc),
      .b     (m),
      .sum   (sum),
      .carry (carry)
   );

   // Conditional add selected by the current multiplier LSB.
   always_comb begin
      acc_add = acc;
      c_add   = 1'b0;
      if (q[0]) begin
         acc_add = sum;
         c_add   = carry;
      end
   end

   // cnt == 0 is both idle and done: the register simply stops moving.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         m   <= '0;
         acc <= '0;
         q   <= '0;
         c   <= 1'b0;
         cnt <= '0;
      end else if (bus.sreset) begin
         m   <= bus.A;
         q   <= bus.B;
         acc <= '0;
         c   <= 1'b0;
         cnt <= CW'(N);
      end else if (cnt != '0) begin
         c   <= 1'b0;
         acc <= {c_add, acc_add[N-1:1]};
         q   <= {acc_add[0], q[N-1:1]};
         cnt <= cnt - CW'(1);
      end
   end

   assign bus.Product = {c, acc, q};

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier (N=4), reference = plain a*b.
// Directed corner cases followed by randomized operand pairs.
module tb_sequential_multiplier;

   localparam int N = 4;
   localparam int W = 2 * N + 1;

   logic clk;
   logic areset;

   sequential_multiplier_if #(.N(N)) bus ();

   sequential_multiplier #(
      .OPERAND_SIZE (N)
   ) dut (
      .clk    (clk),
      .areset (areset),
      .bus    (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int test_count = 0;
   int fail_count = 0;
   logic [W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      test_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_product(input logic [N-1:0] a, input logic [N-1:0] b);
      int p;
      p = int'(a) * int'(b);
      return W'(p);
   endfunction

   // driver: one-cycle start pulse, returns at the negedge after the start edge
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk);
      bus.A      = a;
      bus.B      = b;
      bus.sreset = 1'b1;
      @(negedge clk);
      bus.sreset = 1'b0;
      exp_q.push_back(ref_product(a, b));
   endtask

   task automatic wait_and_check(input string tag);
      logic [W-1:0] exp;
      repeat (N) @(negedge clk);
      exp = exp_q.pop_front();
      check_eq(tag, bus.Product, exp);
   endtask

   task automatic check_hold(input string tag, input int cycles, input logic [W-1:0] exp);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_eq(tag, bus.Product, exp);
      end
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      logic [W-1:0] last;

      areset     = 1'b0;
      bus.sreset = 1'b0;
      bus.A      = '0;
      bus.B      = '0;
      #1;
      check_eq("reset_async", bus.Product, '0);
      repeat (2) @(negedge clk);
      areset = 1'b1;
      check_hold("idle_no_start", 5, '0);

      start_op(4'd0, 4'd5);
      wait_and_check("zero_a");

      start_op(4'd2, 4'd3);
      wait_and_check("a2_b3");
      check_hold("hold_6", 12, 9'd6);

      start_op(4'd5, 4'd5);
      wait_and_check("a5_b5");

      start_op(4'd15, 4'd15);
      wait_and_check("a15_b15");
      check_hold("hold_225", 3, 9'd225);

      // async reset mid-run, cleared before any edge
      start_op(4'd15, 4'd15);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      #2 areset = 1'b0;
      #1 check_eq("areset_mid_run", bus.Product, '0);
      @(negedge clk);
      areset = 1'b1;
      check_hold("idle_after_areset", 6, '0);

      // restart mid-run
      start_op(4'd9, 4'd11);
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      start_op(4'd3, 4'd7);
      wait_and_check("restart_3x7");

      // sreset held several cycles: last operands win
      @(negedge clk);
      bus.sreset = 1'b1;
      bus.A = 4'd1;  bus.B = 4'd1;
      @(negedge clk);
      bus.A = 4'd6;  bus.B = 4'd9;
      @(negedge clk);
      bus.A = 4'd7;  bus.B = 4'd13;
      @(negedge clk);
      bus.sreset = 1'b0;
      exp_q.push_back(ref_product(4'd7, 4'd13));
      wait_and_check("held_sreset_7x13");

      // operands change during the run
      start_op(4'd11, 4'd13);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         bus.A = 4'($urandom_range(0, 15));
         bus.B = 4'($urandom_range(0, 15));
      end
      last = exp_q.pop_front();
      check_eq("ab_change_ignored", bus.Product, last);

      // randomized operand pairs
      for (int k = 0; k < 40; k++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         start_op(ra, rb);
         wait_and_check("random");
         if ($urandom_range(0, 3) == 0)
            check_hold("random_hold", 2, ref_product(ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
